// File: rtl/clk_freq_duty_monitor.sv
// Measures mon_clk period and high time in clk cycles, back to back, with tolerance checks and stuck detection.
// Latency: a report lands 1 cycle after the synchronised closing rise. No backpressure: meas_valid is a one-cycle pulse.
module clk_freq_duty_monitor #(
   parameter int CNT_W      = 16,
   parameter int EXP_PERIOD = 100,
   parameter int EXP_HIGH   = 50,
   parameter int TOL        = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             mon_clk,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period_cnt,
   output logic [CNT_W-1:0] high_cnt,
   output logic             period_ok,
   output logic             duty_ok,
   output logic             stuck,
   output logic [7:0]       err_cnt
);

   // Bounds are one bit wider than the counters so EXP+TOL cannot wrap.
   localparam logic [CNT_W:0] PER_LO = (CNT_W+1)'((TOL > EXP_PERIOD) ? 0 : EXP_PERIOD - TOL);
   localparam logic [CNT_W:0] PER_HI = (CNT_W+1)'(EXP_PERIOD + TOL);
   localparam logic [CNT_W:0] HI_LO  = (CNT_W+1)'((TOL > EXP_HIGH) ? 0 : EXP_HIGH - TOL);
   localparam logic [CNT_W:0] HI_HI  = (CNT_W+1)'(EXP_HIGH + TOL);
   localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hi;
   logic             rise, fall, tmo;
   logic             pok_nxt, dok_nxt;

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign tmo     = (cnt == TMO);
   assign pok_nxt = ({1'b0, cnt} >= PER_LO) && ({1'b0, cnt} <= PER_HI);
   assign dok_nxt = ({1'b0, hi} >= HI_LO) && ({1'b0, hi} <= HI_HI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= mon_clk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         hi         <= '0;
         meas_valid <= 1'b0;
         period_cnt <= '0;
         high_cnt   <= '0;
         period_ok  <= 1'b0;
         duty_ok    <= 1'b0;
         stuck      <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         meas_valid <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  cnt   <= '0;
                  state <= WAIT_RISE;
               end
               WAIT_RISE: begin
                  if (rise) begin
                     cnt   <= CNT_W'(1);
                     state <= MEAS_HIGH;
                  end else if (tmo) begin
                     stuck <= 1'b1;
                     cnt   <= '0;
                     state <= WAIT_RISE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               MEAS_HIGH: begin
                  if (fall) begin
                     hi    <= cnt;
                     cnt   <= cnt + 1'b1;
                     state <= MEAS_LOW;
                  end else if (tmo) begin
                     stuck <= 1'b1;
                     cnt   <= '0;
                     state <= WAIT_RISE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               MEAS_LOW: begin
                  if (rise) begin
                     // The closing rise also opens the next period.
                     period_cnt <= cnt;
                     high_cnt   <= hi;
                     period_ok  <= pok_nxt;
                     duty_ok    <= dok_nxt;
                     meas_valid <= 1'b1;
                     stuck      <= 1'b0;
                     if ((!pok_nxt || !dok_nxt) && (err_cnt != 8'hFF))
                        err_cnt <= err_cnt + 8'd1;
                     cnt   <= CNT_W'(1);
                     state <= MEAS_HIGH;
                  end else if (tmo) begin
                     stuck <= 1'b1;
                     cnt   <= '0;
                     state <= WAIT_RISE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_freq_duty_monitor.sv
// Bench for clk_freq_duty_monitor: table vectors, random periods against an arithmetic model, and multi-cycle corner sequences.
module tb_clk_freq_duty_monitor;
   localparam int CNT_W      = 16;
   localparam int EXP_PERIOD = 100;
   localparam int EXP_HIGH   = 50;
   localparam int TOL        = 2;
   localparam int TIMEOUT    = 1024;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             mon_clk = 1'b0;
   logic             meas_valid;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic             period_ok;
   logic             duty_ok;
   logic             stuck;
   logic [7:0]       err_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int per; int hi; bit pok; bit dok; bit stk; int err; int stamp;
   } rep_t;

   typedef struct {
      int h; int l; int exp_per; int exp_hi; bit exp_pok; bit exp_dok;
   } vec_t;

   rep_t q[$];
   int   rise_q[$];
   int   hs[$];
   int   ls[$];
   vec_t tbl[10];

   clk_freq_duty_monitor #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH), .TOL(TOL), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mon_clk(mon_clk),
      .meas_valid(meas_valid), .period_cnt(period_cnt), .high_cnt(high_cnt),
      .period_ok(period_ok), .duty_ok(duty_ok), .stuck(stuck), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (meas_valid === 1'b1)
         q.push_back('{int'(period_cnt), int'(high_cnt), period_ok, duty_ok, stuck, int'(err_cnt), cyc});

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit in_rng(input int m, input int e);
      int lo;
      lo = (TOL > e) ? 0 : e - TOL;
      return (m >= lo) && (m <= e + TOL);
   endfunction

   task automatic drive_period(input int h, input int l);
      mon_clk = 1'b1;
      rise_q.push_back(cyc + 1);
      repeat (h) @(negedge clk);
      mon_clk = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic close_rise();
      mon_clk = 1'b1;
      rise_q.push_back(cyc + 1);
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; mon_clk = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      q.delete(); rise_q.delete();
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_reports(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (q.size() < n) begin
         errors++;
         $display("FAIL %s: got %0d reports expected %0d", name, q.size(), n);
      end
   endtask

   task automatic chk_rep(input string tag, input int idx, input int ep, input int eh,
                          input bit epok, input bit edok, input int eerr);
      if (idx >= q.size()) return;
      chk({tag, "_period"}, q[idx].per, ep);
      chk({tag, "_high"},   q[idx].hi, eh);
      chk({tag, "_pok"},    q[idx].pok, epok);
      chk({tag, "_dok"},    q[idx].dok, edok);
      chk({tag, "_err"},    q[idx].err, eerr);
      chk({tag, "_stuck"},  q[idx].stk, 0);
   endtask

   initial begin
      int exp_err;
      int k;
      int p;

      tbl[0] = '{50, 50, 100, 50, 1'b1, 1'b1};
      tbl[1] = '{30, 70, 100, 30, 1'b1, 1'b0};
      tbl[2] = '{48, 47,  95, 48, 1'b0, 1'b1};
      tbl[3] = '{48, 50,  98, 48, 1'b1, 1'b1};
      tbl[4] = '{52, 50, 102, 52, 1'b1, 1'b1};
      tbl[5] = '{47, 50,  97, 47, 1'b0, 1'b0};
      tbl[6] = '{53, 50, 103, 53, 1'b0, 1'b0};
      tbl[7] = '{50, 52, 102, 50, 1'b1, 1'b1};
      tbl[8] = '{50, 53, 103, 50, 1'b0, 1'b1};
      tbl[9] = '{50, 47,  97, 50, 1'b0, 1'b1};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_meas_valid", meas_valid, 0);
      chk("rst_period_cnt", period_cnt, 0);
      chk("rst_high_cnt", high_cnt, 0);
      chk("rst_period_ok", period_ok, 0);
      chk("rst_duty_ok", duty_ok, 0);
      chk("rst_stuck", stuck, 0);
      chk("rst_err_cnt", err_cnt, 0);

      // Table vectors: one primed period, then one period per vector
      do_reset();
      drive_period(50, 50);
      for (int i = 0; i < 10; i++) drive_period(tbl[i].h, tbl[i].l);
      close_rise();
      wait_reports(11, 20, "tbl_count");
      chk_rep("tbl_prime", 0, 100, 50, 1'b1, 1'b1, 0);
      if (q.size() > 1 && rise_q.size() > 2) chk("tbl_latency", q[1].stamp - rise_q[2], 2);
      exp_err = 0;
      for (int i = 0; i < 10; i++) begin
         if (!tbl[i].exp_pok || !tbl[i].exp_dok) exp_err++;
         chk_rep($sformatf("tbl%0d", i), i + 1, tbl[i].exp_per, tbl[i].exp_hi,
                 tbl[i].exp_pok, tbl[i].exp_dok, exp_err);
      end

      // Random periods against the arithmetic model
      do_reset();
      hs.delete(); ls.delete();
      drive_period(50, 50);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            hs.push_back(EXP_HIGH - 4 + int'($urandom_range(0, 8)));
            ls.push_back(EXP_PERIOD - EXP_HIGH - 4 + int'($urandom_range(0, 8)));
         end else begin
            hs.push_back(int'($urandom_range(3, 120)));
            ls.push_back(int'($urandom_range(3, 120)));
         end
         drive_period(hs[i], ls[i]);
      end
      close_rise();
      wait_reports(41, 20, "rnd_count");
      exp_err = 0;
      for (int i = 0; i < 40; i++) begin
         p = hs[i] + ls[i];
         if (!in_rng(p, EXP_PERIOD) || !in_rng(hs[i], EXP_HIGH))
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
         chk_rep($sformatf("rnd%0d", i), i + 1, p, hs[i],
                 in_rng(p, EXP_PERIOD), in_rng(hs[i], EXP_HIGH), exp_err);
      end

      // Error counter saturation at 30% duty
      do_reset();
      for (int i = 0; i < 257; i++) drive_period(30, 70);
      close_rise();
      wait_reports(257, 20, "sat_count");
      for (int i = 0; i < q.size(); i++)
         chk($sformatf("sat_err%0d", i), q[i].err, (i + 1 < 255) ? i + 1 : 255);
      if (q.size() > 256) chk("sat_dok", q[256].dok, 0);

      // Stuck: mon_clk held high from enable
      rst_n = 1'b0; enable = 1'b0; mon_clk = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      q.delete(); rise_q.delete();
      enable = 1'b1;
      k = 0;
      while (stuck !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("stuck_delay", k - 1, TIMEOUT);
      repeat (1500) @(negedge clk);
      chk("stuck_held", stuck, 1);
      chk("stuck_no_report", q.size(), 0);
      mon_clk = 1'b0;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 3; i++) drive_period(50, 50);
      close_rise();
      wait_reports(3, 20, "stuck_recover_count");
      chk_rep("stuck_recover", 0, 100, 50, 1'b1, 1'b1, 0);

      // Reset pulse during MEAS_LOW
      do_reset();
      fork
         begin
            for (int i = 0; i < 4; i++) drive_period(50, 50);
            close_rise();
         end
         begin
            repeat (170) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("arst_meas_valid", meas_valid, 0);
            chk("arst_period_cnt", period_cnt, 0);
            chk("arst_high_cnt", high_cnt, 0);
            chk("arst_pok", period_ok, 0);
            chk("arst_dok", duty_ok, 0);
            chk("arst_err_cnt", err_cnt, 0);
            q.delete();
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
      join
      wait_reports(2, 20, "arst_count");
      if (q.size() > 0 && rise_q.size() > 3) chk("arst_first_stamp", q[0].stamp - rise_q[3], 2);
      chk_rep("arst_first", 0, 100, 50, 1'b1, 1'b1, 0);

      // Enable dropped and restored inside a high phase, then a 90 degree phase shift
      do_reset();
      fork
         begin
            drive_period(50, 50);
            drive_period(50, 75);
            drive_period(50, 50);
            drive_period(50, 50);
            close_rise();
         end
         begin
            repeat (110) @(negedge clk);
            enable = 1'b0;
            q.delete();
            repeat (20) @(negedge clk);
            chk("en_no_report", q.size(), 0);
            chk("en_hold_period", period_cnt, 100);
            chk("en_hold_high", high_cnt, 50);
            chk("en_hold_pok", period_ok, 1);
            chk("en_hold_dok", duty_ok, 1);
            chk("en_hold_err", err_cnt, 0);
            enable = 1'b1;
         end
      join
      wait_reports(2, 20, "en_count");
      if (q.size() > 0 && rise_q.size() > 3) chk("en_first_stamp", q[0].stamp - rise_q[3], 2);
      chk_rep("en_first", 0, 100, 50, 1'b1, 1'b1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
